// File: rtl/m_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : m_serial_rx
// Purpose  : Receive end of the LSB-first bit-serial datapath. Deserializes
//            two serial operand streams into parallel words and forms their
//            sum bit by bit while the word arrives. Each finished word is
//            offered through a single-entry valid/ready output register.
//            Framing errors (early start-of-word) and overruns (word finished
//            while the output register is still occupied) raise sticky flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   w_clk    in   clock, rising edge
//   w_rst_n  in   asynchronous active-low reset
//   w_sval   in   serial bit valid (qualifies w_ssof/w_sa/w_sb)
//   w_ssof   in   start of word, accompanies bit 0
//   w_sa     in   operand A serial bit, LSB first
//   w_sb     in   operand B serial bit, LSB first
//   w_rdy    in   downstream ready
//   w_clr    in   synchronous clear of sticky flags
//   r_vld    out  output word valid
//   r_a      out  deserialized operand A
//   r_b      out  deserialized operand B
//   r_sum    out  (A+B) mod 2^WIDTH
//   r_cout   out  carry out of bit WIDTH-1
//   r_ferr   out  sticky framing error
//   r_ovr    out  sticky overrun
// ============================================================================
module m_serial_rx #(
  parameter int WIDTH = 32
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic             w_sval,
  input  logic             w_ssof,
  input  logic             w_sa,
  input  logic             w_sb,
  input  logic             w_rdy,
  input  logic             w_clr,
  output logic             r_vld,
  output logic [WIDTH-1:0] r_a,
  output logic [WIDTH-1:0] r_b,
  output logic [WIDTH-1:0] r_sum,
  output logic             r_cout,
  output logic             r_ferr,
  output logic             r_ovr
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   ss_q, ss_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               vld_q, vld_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;

  logic               take_bit;
  logic               first_bit;
  logic               word_done;
  logic               ferr_set;
  logic               ovr_set;
  logic               slot_free;
  logic               cin;
  logic               bit_s;
  logic               bit_c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    ss_d      = ss_q;
    c_d       = c_q;
    take_bit  = 1'b0;
    first_bit = 1'b0;
    word_done = 1'b0;
    ferr_set  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Bits without a start-of-word are ignored while idle.
        if (w_sval && w_ssof) begin
          take_bit  = 1'b1;
          first_bit = 1'b1;
          cnt_d     = CNT_W'(1);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_sval) begin
          take_bit = 1'b1;
          if (w_ssof) begin
            // Early start: the partial word is abandoned and this bit
            // restarts reception. This also covers w_ssof on the final bit.
            first_bit = 1'b1;
            ferr_set  = 1'b1;
            cnt_d     = CNT_W'(1);
          end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
            word_done = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Serial full adder; carry chain restarts on bit 0 of every word.
    cin   = first_bit ? 1'b0 : c_q;
    bit_s = w_sa ^ w_sb ^ cin;
    bit_c = (w_sa & w_sb) | (w_sa & cin) | (w_sb & cin);

    // New bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
    if (take_bit) begin
      sa_d = {w_sa,  sa_q[WIDTH-1:1]};
      sb_d = {w_sb,  sb_q[WIDTH-1:1]};
      ss_d = {bit_s, ss_q[WIDTH-1:1]};
      c_d  = bit_c;
    end
  end

  always_comb begin
    // The single output slot is free if empty or draining on this edge.
    slot_free = !vld_q || w_rdy;
    ovr_set   = word_done && !slot_free;

    vld_d  = vld_q && !w_rdy;
    a_d    = a_q;
    b_d    = b_q;
    sum_d  = sum_q;
    cout_d = cout_q;

    if (word_done && slot_free) begin
      vld_d  = 1'b1;
      a_d    = sa_d;
      b_d    = sb_d;
      sum_d  = ss_d;
      cout_d = c_d;
    end

    // Set takes priority over a coincident clear.
    ferr_d = (ferr_q && !w_clr) || ferr_set;
    ovr_d  = (ovr_q  && !w_clr) || ovr_set;
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      ss_q    <= '0;
      c_q     <= 1'b0;
      vld_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ss_q    <= ss_d;
      c_q     <= c_d;
      vld_q   <= vld_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign r_vld  = vld_q;
  assign r_a    = a_q;
  assign r_b    = b_q;
  assign r_sum  = sum_q;
  assign r_cout = cout_q;
  assign r_ferr = ferr_q;
  assign r_ovr  = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_m_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_serial_rx
// Purpose  : Self-checking bench for m_serial_rx (WIDTH=32). Expected output
//            words are queued as stimulus is sent and compared when the DUT
//            presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_serial_rx;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
  } word_t;

  logic         w_clk = 1'b0;
  logic         w_rst_n;
  logic         w_sval, w_ssof, w_sa, w_sb, w_rdy, w_clr;
  logic         r_vld, r_cout, r_ferr, r_ovr;
  logic [W-1:0] r_a, r_b, r_sum;

  word_t        sb_q[$];
  word_t        exp_w;
  word_t        got_w;
  int           n_checks = 0;
  int           n_fail   = 0;

  m_serial_rx #(.WIDTH(W)) dut (
    .w_clk  (w_clk),
    .w_rst_n(w_rst_n),
    .w_sval (w_sval),
    .w_ssof (w_ssof),
    .w_sa   (w_sa),
    .w_sb   (w_sb),
    .w_rdy  (w_rdy),
    .w_clr  (w_clr),
    .r_vld  (r_vld),
    .r_a    (r_a),
    .r_b    (r_b),
    .r_sum  (r_sum),
    .r_cout (r_cout),
    .r_ferr (r_ferr),
    .r_ovr  (r_ovr)
  );

  always #5 w_clk = ~w_clk;

  assign got_w = '{a: r_a, b: r_b, sum: r_sum, cout: r_cout};

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  function automatic void push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b};
    sb_q.push_back('{a: a, b: b, sum: full[W-1:0], cout: full[W]});
  endfunction

  // Sends bits [first, first+cnt) of a/b; bit 0 carries w_ssof. Optional
  // random idle gaps (with garbage on the unqualified inputs) precede each bit.
  task automatic send_bits(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int first, input int cnt, input int gapmax);
    int g;
    for (int i = first; i < first + cnt; i++) begin
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      repeat (g) begin
        w_sval = 1'b0;
        w_ssof = 1'($urandom);
        w_sa   = 1'($urandom);
        w_sb   = 1'($urandom);
        tick();
      end
      w_sval = 1'b1;
      w_ssof = (i == 0);
      w_sa   = a[i];
      w_sb   = b[i];
      tick();
    end
    w_sval = 1'b0;
    w_ssof = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({r_vld, r_a, r_b, r_sum, r_cout, r_ferr, r_ovr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld=%b a=%h b=%h sum=%h cout=%b ferr=%b ovr=%b, want all 0",
               r_vld, r_a, r_b, r_sum, r_cout, r_ferr, r_ovr);
    end
  endtask

  task automatic test_basic();
    w_rdy = 1'b1;
    push_exp(32'h5, 32'h3);
    send_bits(32'h5, 32'h3, 0, 31, 0);
    n_checks++;
    if (r_vld !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_vld: got %b want 0", r_vld);
    end
    send_bits(32'h5, 32'h3, 31, 1, 0);
    n_checks++;
    if (r_vld !== 1'b1) begin
      n_fail++; $display("FAIL basic_vld: got %b want 1", r_vld);
    end
    exp_w = sb_q.pop_front();
    n_checks++;
    if (got_w !== exp_w) begin
      n_fail++; $display("FAIL basic_word: got %h want %h", got_w, exp_w);
    end
    n_checks++;
    if ({r_ferr, r_ovr} !== 2'b00) begin
      n_fail++; $display("FAIL basic_flags: got %b want 00", {r_ferr, r_ovr});
    end
    tick();
    n_checks++;
    if (r_vld !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse: got vld %b want 0", r_vld);
    end
  endtask

  task automatic test_gaps();
    w_rdy = 1'b1;
    push_exp(32'hFFFF_FFFF, 32'h1);
    send_bits(32'hFFFF_FFFF, 32'h1, 0, 32, 3);
    n_checks++;
    if (r_vld !== 1'b1) begin
      n_fail++; $display("FAIL gaps_vld: got %b want 1", r_vld);
    end
    exp_w = sb_q.pop_front();
    n_checks++;
    if (got_w !== exp_w) begin
      n_fail++; $display("FAIL gaps_word: got %h want %h", got_w, exp_w);
    end
    tick();
    n_checks++;
    if (r_vld !== 1'b0) begin
      n_fail++; $display("FAIL gaps_pulse: got vld %b want 0", r_vld);
    end
  endtask

  task automatic test_ferr();
    w_rdy = 1'b1;
    n_checks++;
    if (r_ferr !== 1'b0) begin
      n_fail++; $display("FAIL ferr_pre: got %b want 0", r_ferr);
    end
    send_bits(32'h1234_5678, 32'h0, 0, 10, 0);
    push_exp(32'hA, 32'h5);
    send_bits(32'hA, 32'h5, 0, 1, 0);
    n_checks++;
    if (r_ferr !== 1'b1) begin
      n_fail++; $display("FAIL ferr_set: got %b want 1", r_ferr);
    end
    send_bits(32'hA, 32'h5, 1, 31, 0);
    n_checks++;
    if (r_vld !== 1'b1) begin
      n_fail++; $display("FAIL ferr_vld: got %b want 1", r_vld);
    end
    exp_w = sb_q.pop_front();
    n_checks++;
    if (got_w !== exp_w) begin
      n_fail++; $display("FAIL ferr_word: got %h want %h", got_w, exp_w);
    end
    w_clr = 1'b1;
    tick();
    w_clr = 1'b0;
    n_checks++;
    if ({r_ferr, r_ovr} !== 2'b00) begin
      n_fail++; $display("FAIL ferr_clear: got %b want 00", {r_ferr, r_ovr});
    end
  endtask

  task automatic test_overrun();
    w_rdy = 1'b0;
    push_exp(32'h1, 32'h2);
    send_bits(32'h1, 32'h2, 0, 32, 0);
    send_bits(32'h3, 32'h4, 0, 16, 0);
    n_checks++;
    if (got_w !== sb_q[0] || r_vld !== 1'b1) begin
      n_fail++; $display("FAIL ovr_hold_mid: got vld=%b %h want vld=1 %h", r_vld, got_w, sb_q[0]);
    end
    send_bits(32'h3, 32'h4, 16, 16, 0);
    n_checks++;
    if (r_ovr !== 1'b1) begin
      n_fail++; $display("FAIL ovr_set: got %b want 1", r_ovr);
    end
    exp_w = sb_q.pop_front();
    n_checks++;
    if (got_w !== exp_w || r_vld !== 1'b1) begin
      n_fail++; $display("FAIL ovr_hold: got vld=%b %h want vld=1 %h", r_vld, got_w, exp_w);
    end
    w_rdy = 1'b1;
    tick();
    n_checks++;
    if (r_vld !== 1'b0) begin
      n_fail++; $display("FAIL ovr_transfer: got vld %b want 0", r_vld);
    end
    w_clr = 1'b1;
    tick();
    w_clr = 1'b0;
    n_checks++;
    if (r_ovr !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clear: got %b want 0", r_ovr);
    end
  endtask

  task automatic test_back_to_back();
    w_rdy = 1'b0;
    push_exp(32'h2, 32'h2);
    send_bits(32'h2, 32'h2, 0, 32, 0);
    send_bits(32'h3, 32'h4, 0, 31, 0);
    exp_w = sb_q.pop_front();
    n_checks++;
    if (got_w !== exp_w || r_vld !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: got vld=%b %h want vld=1 %h", r_vld, got_w, exp_w);
    end
    push_exp(32'h3, 32'h4);
    w_rdy = 1'b1;
    send_bits(32'h3, 32'h4, 31, 1, 0);
    n_checks++;
    if (r_vld !== 1'b1 || r_ovr !== 1'b0) begin
      n_fail++; $display("FAIL b2b_flags: got vld=%b ovr=%b want vld=1 ovr=0", r_vld, r_ovr);
    end
    exp_w = sb_q.pop_front();
    n_checks++;
    if (got_w !== exp_w) begin
      n_fail++; $display("FAIL b2b_second: got %h want %h", got_w, exp_w);
    end
    tick();
    n_checks++;
    if (r_vld !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: got vld %b want 0", r_vld);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    w_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = $urandom;
      b = $urandom;
      push_exp(a, b);
      send_bits(a, b, 0, 32, (k % 2) * 2);
      exp_w = sb_q.pop_front();
      n_checks++;
      if (got_w !== exp_w || r_vld !== 1'b1) begin
        n_fail++; $display("FAIL random_word%0d: got vld=%b %h want vld=1 %h", k, r_vld, got_w, exp_w);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    w_rdy = 1'b0;
    push_exp(32'h11, 32'h22);
    send_bits(32'h11, 32'h22, 0, 32, 0);
    exp_w = sb_q.pop_front();
    n_checks++;
    if (got_w !== exp_w || r_vld !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_load: got vld=%b %h want vld=1 %h", r_vld, got_w, exp_w);
    end
    send_bits(32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 15, 0);
    w_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({r_vld, r_a, r_b, r_sum, r_cout, r_ferr, r_ovr} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got vld=%b a=%h b=%h sum=%h cout=%b ferr=%b ovr=%b, want all 0",
               r_vld, r_a, r_b, r_sum, r_cout, r_ferr, r_ovr);
    end
    tick();
    w_rst_n = 1'b1;
    w_rdy   = 1'b1;
    tick();
    push_exp(32'h8000_0000, 32'h8000_0000);
    send_bits(32'h8000_0000, 32'h8000_0000, 0, 32, 0);
    exp_w = sb_q.pop_front();
    n_checks++;
    if (got_w !== exp_w || r_vld !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_word: got vld=%b %h want vld=1 %h", r_vld, got_w, exp_w);
    end
    n_checks++;
    if ({r_ferr, r_ovr} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_flags: got %b want 00", {r_ferr, r_ovr});
    end
  endtask

  initial begin
    w_rst_n = 1'b0;
    w_sval  = 1'b0;
    w_ssof  = 1'b0;
    w_sa    = 1'b0;
    w_sb    = 1'b0;
    w_rdy   = 1'b0;
    w_clr   = 1'b0;
    tick();
    tick();
    test_reset();
    w_rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_gaps();
    test_ferr();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m_serial_rx.md
# m_serial_rx

Bit-serial operand receiver and adder: the receive end of the team's LSB-first bit-serial datapath. It accepts two synchronous serial bit streams, deserializes them into parallel words, and accumulates their sum bit by bit during reception. Each completed word is presented as a parallel result through a valid/ready handshake. It sits between a serial link or serial ALU front end and the parallel register/writeback logic, and it flags framing errors and overruns.

## Interface
- WIDTH, 32, word length in bits (≥2)
- w_clk  in  1  clock, rising-edge
- w_rst_n  in  1  asynchronous active-low reset
- w_sval  in  1  serial bit valid; w_sa/w_sb/w_ssof are sampled only when high
- w_ssof  in  1  start of word; high together with bit 0
- w_sa  in  1  operand A serial bit, LSB first
- w_sb  in  1  operand B serial bit, LSB first
- w_rdy  in  1  downstream ready
- w_clr  in  1  synchronous clear of sticky flags
- r_vld  out  1  output word valid
- r_a  out  WIDTH  deserialized operand A
- r_b  out  WIDTH  deserialized operand B
- r_sum  out  WIDTH  (A+B) mod 2^WIDTH
- r_cout  out  1  carry out of bit WIDTH-1
- r_ferr  out  1  sticky framing error
- r_ovr  out  1  sticky overrun

## Operation
- Internal state: shift registers sa/sb/ss (WIDTH each), carry c, bit counter cnt (clog2(WIDTH)+1 bits), state IDLE/SHIFT.
- Bit accept: on a sampled bit, s = w_sa^w_sb^cin and cout = maj(w_sa,w_sb,cin). Each shift register shifts right with the new bit entering at the MSB. After WIDTH bits, bit 0 sits at the LSB.
- cin is 0 for bit 0 and c otherwise.
- IDLE: w_sval&w_ssof accepts bit 0, sets cnt=1 and goes to SHIFT. w_sval without w_ssof is ignored. No flag is set.
- SHIFT: w_sval low means stall with no state change; gaps of any length are legal.
- SHIFT, w_sval&!w_ssof: accept the bit and increment cnt.
- SHIFT, w_sval&w_ssof (premature start): set r_ferr, discard the partial word, and accept the current bit as bit 0 of a new word with cnt=1. State stays SHIFT.
- Word complete, meaning a bit is accepted with cnt==WIDTH-1:
  - Output slot free, i.e. !r_vld or (r_vld&w_rdy) this cycle: load r_a/r_b/r_sum with the final shifted values, load r_cout with the final carry, and set r_vld.
  - Otherwise: drop the word, set r_ovr, and leave the output registers unchanged.
  - Either way, go to IDLE and set cnt=0.
- w_ssof on the final bit is a premature start; the rule above applies and the word does not complete.
- Handshake: the transfer happens on a cycle with r_vld&w_rdy. r_vld clears after the transfer unless a new word loads on the same edge.
- r_a/r_b/r_sum/r_cout hold stable while r_vld is high and w_rdy is low.
- Sticky flags: w_clr clears r_ferr/r_ovr. If a set condition coincides with w_clr, set wins.
- Reset (any time, including mid-word): all outputs and internal registers go to 0 and state goes to IDLE. The partial word is lost.

## Timing
- Reset values: r_vld=0, r_a=r_b=r_sum=0, r_cout=0, r_ferr=0, r_ovr=0.
- Latency: the final bit is sampled at edge k and r_vld is high from edge k.
- A gapless word occupies WIDTH consecutive cycles.
- Back-to-back: w_ssof may assert in the cycle right after the final bit. Sustained throughput is one word per WIDTH cycles.
- The output register is single-entry. Reception of the next word proceeds while r_vld is held. Overrun occurs only at completion of the next word.
- Flag updates are visible the cycle after the causing edge. w_clr takes effect at the edge where it is sampled.

## Test plan
- WIDTH=32, gapless A=0x00000005, B=0x00000003, w_rdy=1 -> r_vld pulses 1 cycle after bit 31; r_a=0x5, r_b=0x3, r_sum=0x00000008, r_cout=0; no flags.
- A=0xFFFFFFFF, B=0x00000001, with random w_sval gaps -> r_sum=0x00000000, r_cout=1; latency from last bit unchanged by gaps.
- w_ssof reasserted at bit 10 of word A=0x12345678, then a full word A=0xA, B=0x5 -> r_ferr=1; output r_sum=0xF, r_cout=0; w_clr then returns r_ferr to 0.
- w_rdy=0, two back-to-back words (1+2, then 3+4) -> first word is held with r_sum=0x3; r_ovr=1 at the end of the second word; output still 0x3. Then w_rdy=1 -> transfer, r_vld=0.
- w_rdy=0 during word 1; w_rdy=1 on exactly the edge word 2 completes -> word 2 (r_sum=0x7) loads, r_vld stays 1, r_ovr=0.
- w_rst_n low at bit 15 of a word, then released and a full word 0x80000000+0x80000000 sent -> all outputs 0 during reset; then r_sum=0x0, r_cout=1, no r_ferr.
